// File: rtl/vt52_pkg.sv
// VT52 character RAM scheduler: shared constants, op codes, sequencer state.
// Optional CPU readback port is built when VT52_VRAM_READBACK_EN is defined.
package vt52_pkg;

    localparam int         COLS      = 80;
    localparam int         ROWS      = 24;
    localparam logic [7:0] FILL_CHAR = 8'h20;

    localparam logic [1:0] OP_CLR_ROW = 2'd0;
    localparam logic [1:0] OP_SCROLL  = 2'd1;
    localparam logic [1:0] OP_CLR_ALL = 2'd2;
    localparam logic [1:0] OP_NOP     = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR_ROW,
        S_CLR_ALL
    } seq_state_t;

    // Both operands are below rows, so one conditional subtract wraps.
    function automatic logic [4:0] prow_f(
        input logic [4:0] top,
        input logic [4:0] row,
        input int         rows
    );
        logic [5:0] sum;
        sum = {1'b0, top} + {1'b0, row};
        if (sum >= 6'(rows)) begin
            sum = sum - 6'(rows);
        end
        return sum[4:0];
    endfunction

endpackage

// File: rtl/vt52_vram_sched_if.sv
// Client and RAM bus bundle of the VT52 character RAM scheduler.
// Readback signals exist only when VT52_VRAM_READBACK_EN is defined.
interface vt52_vram_sched_if;

    logic        vid_req;
    logic [4:0]  vid_row;
    logic [6:0]  vid_col;
    logic        vid_valid;
    logic [7:0]  vid_data;

    logic        wr_req;
    logic [4:0]  wr_row;
    logic [6:0]  wr_col;
    logic [7:0]  wr_data;
    logic        wr_ack;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_row;
    logic        busy;
    logic [4:0]  top_row;

    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

`ifdef VT52_VRAM_READBACK_EN
    logic        rd_req;
    logic [4:0]  rd_row;
    logic [6:0]  rd_col;
    logic        rd_ack;
    logic [7:0]  rd_data;

    modport slave (
        input  vid_req, vid_row, vid_col,
        input  wr_req, wr_row, wr_col, wr_data,
        input  cmd_valid, cmd_op, cmd_row,
        input  ram_rdata,
        input  rd_req, rd_row, rd_col,
        output vid_valid, vid_data, wr_ack,
        output cmd_ready, busy, top_row,
        output ram_addr, ram_we, ram_wdata,
        output rd_ack, rd_data
    );

    modport master (
        output vid_req, vid_row, vid_col,
        output wr_req, wr_row, wr_col, wr_data,
        output cmd_valid, cmd_op, cmd_row,
        output ram_rdata,
        output rd_req, rd_row, rd_col,
        input  vid_valid, vid_data, wr_ack,
        input  cmd_ready, busy, top_row,
        input  ram_addr, ram_we, ram_wdata,
        input  rd_ack, rd_data
    );
`else
    modport slave (
        input  vid_req, vid_row, vid_col,
        input  wr_req, wr_row, wr_col, wr_data,
        input  cmd_valid, cmd_op, cmd_row,
        input  ram_rdata,
        output vid_valid, vid_data, wr_ack,
        output cmd_ready, busy, top_row,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_row, vid_col,
        output wr_req, wr_row, wr_col, wr_data,
        output cmd_valid, cmd_op, cmd_row,
        output ram_rdata,
        input  vid_valid, vid_data, wr_ack,
        input  cmd_ready, busy, top_row,
        input  ram_addr, ram_we, ram_wdata
    );
`endif

endinterface

// File: rtl/vt52_addr_map.sv
// Logical (row, col) to physical character RAM address under a scroll origin.
module vt52_addr_map #(
    parameter int COLS = vt52_pkg::COLS,
    parameter int ROWS = vt52_pkg::ROWS
) (
    input  logic [4:0]  top_i,
    input  logic [4:0]  row_i,
    input  logic [6:0]  col_i,
    output logic [10:0] addr_o
);
    import vt52_pkg::*;

    logic [4:0] prow;

    assign prow   = prow_f(top_i, row_i, ROWS);
    assign addr_o = 11'(prow) * 11'(COLS) + 11'(col_i);

endmodule

// File: rtl/vt52_vram_sched.sv
// VT52 character RAM scheduler: video > sequencer > (readback) > write slots.
// Define VT52_VRAM_READBACK_EN to add the rd_* readback client.
module vt52_vram_sched #(
    parameter int         COLS      = vt52_pkg::COLS,
    parameter int         ROWS      = vt52_pkg::ROWS,
    parameter int         RAM_LAT   = 1,
    parameter logic [7:0] FILL_CHAR = vt52_pkg::FILL_CHAR
) (
    input  logic            clk,
    input  logic            reset_n,
    vt52_vram_sched_if.slave bus
);
    import vt52_pkg::*;

    seq_state_t   state_q, state_d;
    logic [4:0]   top_q, top_d;
    logic [4:0]   row_q, row_d;
    logic [6:0]   col_q, col_d;

    logic [10:0]  addr_q, addr_d;
    logic         we_q, we_d;
    logic [7:0]   wdata_q, wdata_d;
    logic         ack_q, ack_d;
    logic [RAM_LAT:0] vpipe_q;

    logic [10:0]  vid_addr, wr_addr, seq_addr;
    logic         busy, cmd_fire;
    logic         g_vid, g_seq, g_wr;
    logic         col_last, row_last;

    vt52_addr_map #(.COLS(COLS), .ROWS(ROWS)) u_map_vid (
        .top_i  (top_q),
        .row_i  (bus.vid_row),
        .col_i  (bus.vid_col),
        .addr_o (vid_addr)
    );

    vt52_addr_map #(.COLS(COLS), .ROWS(ROWS)) u_map_wr (
        .top_i  (top_q),
        .row_i  (bus.wr_row),
        .col_i  (bus.wr_col),
        .addr_o (wr_addr)
    );

    // Sequencer already holds a physical row, so no origin offset.
    vt52_addr_map #(.COLS(COLS), .ROWS(ROWS)) u_map_seq (
        .top_i  (5'd0),
        .row_i  (row_q),
        .col_i  (col_q),
        .addr_o (seq_addr)
    );

`ifdef VT52_VRAM_READBACK_EN
    logic [10:0]      rd_addr;
    logic             g_rd;
    logic [RAM_LAT:0] rpipe_q;

    vt52_addr_map #(.COLS(COLS), .ROWS(ROWS)) u_map_rd (
        .top_i  (top_q),
        .row_i  (bus.rd_row),
        .col_i  (bus.rd_col),
        .addr_o (rd_addr)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            top_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign col_last = (col_q == 7'(COLS - 1));
    assign row_last = (row_q == 5'(ROWS - 1));

    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    col_d = '0;
                    unique case (bus.cmd_op)
                        OP_CLR_ROW: begin
                            state_d = S_CLR_ROW;
                            row_d   = prow_f(top_q, bus.cmd_row, ROWS);
                        end
                        OP_SCROLL: begin
                            state_d = S_CLR_ROW;
                            row_d   = top_q;
                            top_d   = row_last_of(top_q);
                        end
                        OP_CLR_ALL: begin
                            state_d = S_CLR_ALL;
                            row_d   = '0;
                            top_d   = '0;
                        end
                        OP_NOP: ;
                        default: ;
                    endcase
                end
            end
            S_CLR_ROW: begin
                if (g_seq) begin
                    col_d = col_last ? 7'd0 : col_q + 7'd1;
                    if (col_last) state_d = S_IDLE;
                end
            end
            S_CLR_ALL: begin
                if (g_seq) begin
                    col_d = col_last ? 7'd0 : col_q + 7'd1;
                    if (col_last) begin
                        row_d = row_q + 5'd1;
                        if (row_last) state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    function automatic logic [4:0] row_last_of(input logic [4:0] t);
        return (t == 5'(ROWS - 1)) ? 5'd0 : t + 5'd1;
    endfunction

    // Slot arbitration; a write never issues in a command accept cycle,
    // so its ack cannot land while the sequencer is running.
    always_comb begin
        busy     = (state_q != S_IDLE);
        cmd_fire = bus.cmd_valid & ~busy;
        g_vid    = bus.vid_req;
        g_seq    = ~g_vid & busy;
`ifdef VT52_VRAM_READBACK_EN
        g_rd     = ~g_vid & ~busy & bus.rd_req & ~(|rpipe_q);
        g_wr     = ~g_vid & ~busy & ~g_rd & bus.wr_req & ~ack_q & ~cmd_fire;
`else
        g_wr     = ~g_vid & ~busy & bus.wr_req & ~ack_q & ~cmd_fire;
`endif
    end

    always_comb begin
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        unique case (1'b1)
            g_vid: addr_d = vid_addr;
            g_seq: begin
                addr_d  = seq_addr;
                we_d    = 1'b1;
                wdata_d = FILL_CHAR;
            end
`ifdef VT52_VRAM_READBACK_EN
            g_rd: addr_d = rd_addr;
`endif
            g_wr: begin
                addr_d  = wr_addr;
                we_d    = 1'b1;
                wdata_d = bus.wr_data;
                ack_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            vpipe_q <= '0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            vpipe_q <= (vpipe_q << 1) | (RAM_LAT + 1)'(g_vid);
        end
    end

    assign bus.vid_valid = vpipe_q[RAM_LAT];
    assign bus.vid_data  = vpipe_q[RAM_LAT] ? bus.ram_rdata : 8'h00;
    assign bus.wr_ack    = ack_q;
    assign bus.cmd_ready = ~busy;
    assign bus.busy      = busy;
    assign bus.top_row   = top_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_wdata = wdata_q;

`ifdef VT52_VRAM_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpipe_q <= '0;
        end else begin
            rpipe_q <= (rpipe_q << 1) | (RAM_LAT + 1)'(g_rd);
        end
    end

    assign bus.rd_ack  = rpipe_q[RAM_LAT];
    assign bus.rd_data = rpipe_q[RAM_LAT] ? bus.ram_rdata : 8'h00;
`endif

endmodule

// File: doc/vt52_vram_sched.md
Name: vt52_vram_sched

Overview:
- Scheduler for the VT52 character RAM, which is single-port with 2048 x 8 cells.
- Shares the RAM between three clients:
  - the video character fetch (fixed priority, never stalled);
  - the terminal engine's cell writes;
  - an internal clear/scroll sequencer.
- Owns the scroll origin register (top_row) and maps logical (row, col) to a physical address.
- Sits between the terminal escape-sequence parser and the VT52 video core inside the emu top.

Parameters:
- COLS, 80, characters per row.
- ROWS, 24, rows per screen.
- RAM_LAT, 1, RAM read latency in cycles, from registered address to valid ram_rdata.
- FILL_CHAR, 8'h20, code written by clear operations.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vid_req  in  1  video fetch strobe, one cycle per character.
- vid_row  in  5  logical row of the fetch.
- vid_col  in  7  logical column of the fetch.
- vid_valid  out  1  vid_data is valid.
- vid_data  out  8  fetched character.
- wr_req  in  1  cell write request; held with stable fields until wr_ack.
- wr_row  in  5  logical row of the write.
- wr_col  in  7  logical column of the write.
- wr_data  in  8  character to write.
- wr_ack  out  1  one-cycle pulse: write issued to RAM.
- cmd_valid  in  1  command handshake valid.
- cmd_ready  out  1  command handshake ready.
- cmd_op  in  2  0=clear row, 1=scroll up, 2=clear screen, 3=reserved (no-op).
- cmd_row  in  5  logical row for op 0.
- busy  out  1  sequencer not IDLE.
- top_row  out  5  current scroll origin.
- ram_addr  out  11  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  8  registered RAM write data.
- ram_rdata  in  8  RAM read data.

Behaviour:
- Reset values: all outputs 0 and FSM in IDLE, except cmd_ready=1. RAM contents are untouched by reset.
- Address map: prow = (top_row + row) mod ROWS, computed without overflow beyond 5 bits; addr = prow*COLS + col. Out-of-range row/col inputs are unspecified.
- Slot arbitration, evaluated every cycle:
  - vid_req takes the slot first.
  - Otherwise, the sequencer takes it if busy.
  - Otherwise, wr_req takes it.
  - The RAM control registers load at the end of the cycle.
- Video path: vid_valid pulses exactly 1+RAM_LAT cycles after vid_req, with vid_data = ram_rdata at that cycle. Back-to-back vid_req is supported and is fully pipelined.
- Write path: wr_ack is asserted in the same cycle ram_we=1 is visible for that write. It is never asserted while busy. Writes issued before a command is accepted complete first.
- Command handshake: cmd_ready = IDLE. A command is accepted on cmd_valid & cmd_ready. cmd_op=3 is accepted and ignored.
- FSM states:
  - IDLE.
  - CLR_ROW: col counter runs 0..COLS-1 on granted slots only; the row is fixed.
  - CLR_ALL: the same, iterating physical rows 0..ROWS-1.
  - Transitions:
    - Op 0: IDLE -> CLR_ROW with prow = map(cmd_row).
    - Op 1: top_row increments mod ROWS (23 -> 0) in the accept cycle, then the FSM goes to CLR_ROW on the old top_row. That physical row is the new bottom row.
    - Op 2: IDLE -> CLR_ALL, and top_row is reset to 0.
    - Terminal: the last col granted returns the FSM to IDLE (last col of the last row, for CLR_ALL). busy drops the cycle after that last ram_we.
- Sequencer writes FILL_CHAR. Its counter advances only when a slot is granted, so video fetches starve it without corrupting it.
- Clear durations with no video traffic: op 0/1 takes exactly COLS write cycles; op 2 takes ROWS*COLS write cycles.
- Video fetches during a clear see partially cleared data; this is allowed.
- Reset mid-operation: the FSM returns to IDLE immediately and top_row=0. Remaining cells keep old contents.

Optional Feature:
- Macro: VT52_VRAM_READBACK_EN.
- When defined:
  - Adds ports rd_req (in, 1), rd_row (in, 5), rd_col (in, 7), rd_ack (out, 1), rd_data (out, 8).
  - Readback sits in the arbitration below the sequencer and above wr_req.
  - rd_ack and rd_data pulse 1+RAM_LAT cycles after the grant.
  - rd_req is held until the grant; the grant is signalled internally, and the requester waits for rd_ack.
- When not defined: no such ports exist, and arbitration is video > sequencer > write.

Decomposition:
- Package vt52_pkg holds:
  - COLS, ROWS and FILL_CHAR defaults;
  - the cmd_op encoding localparams: OP_CLR_ROW, OP_SCROLL, OP_CLR_ALL, OP_NOP;
  - the sequencer state typedef.
- Sub-module vt52_addr_map is combinational: (top_row, row, col) -> 11-bit addr. It is instantiated once per client.

Test Plan:
- After reset, write 'A' at (0,0) with top_row=0: ram_we with ram_addr=0 and ram_wdata=8'h41, wr_ack in the same cycle. A vid_req to (0,0) then returns vid_data=8'h41 two cycles later (RAM_LAT=1).
- Hold vid_req continuously for 10 cycles while wr_req is pending: no wr_ack until the first idle slot. vid_valid forms a continuous 10-cycle train.
- cmd_op=1 with top_row=23: top_row becomes 0, physical row 23 (addr 1840..1919) is filled with 8'h20 in 80 cycles, busy stays high for 80 cycles, and cmd_ready=0 throughout.
- cmd_op=2 with one vid_req every 2nd cycle: 1920 fill writes complete in 3840 cycles, and no write is lost or duplicated (checked via a RAM model).
- Issue a write during a clear-row: wr_ack is withheld until busy falls; the write lands after the last fill write.
- Assert reset_n=0 mid-CLR_ALL at cell 500: the FSM is in IDLE and top_row=0 on the next clock. Cells 500 and up keep their prior contents.
